li_expander: RTL and testbench

Pseudo-instruction expander: accepts a load-immediate request (32-bit constant plus destination register) and emits the minimal RV32I sequence that materialises it, either one instruction (ADDI or LUI) or two (LUI then ADDI). It encodes immediates into their instruction fields, the inverse of the core's decode-side immediate extraction. It sits between the debug/boot instruction-injection port and the fetch stage mux. Both sides use valid/ready handshakes.

---
 rtl/li_expander_pkg.sv | 27 ++
 rtl/li_split.sv | 25 ++
 rtl/li_expander.sv | 104 ++++++++++
 tb/tb_li_expander.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/li_expander_pkg.sv
// Shared defines for the load-immediate expander: widths, opcodes, encoders.
package li_expander_pkg;

    localparam int unsigned WORD_LEN = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_LO_W = 12;
    localparam int unsigned IMM_HI_W = WORD_LEN - IMM_LO_W;

    localparam logic [6:0]          OP_LUI    = 7'b0110111;
    localparam logic [6:0]          OP_IMM    = 7'b0010011;
    localparam logic [2:0]          F3_ADDI   = 3'b000;
    localparam logic [WORD_LEN-1:0] NOP_INSTR = 32'h0000_0013;

    // LUI rd, hi
    function automatic logic [WORD_LEN-1:0] enc_lui(input logic [IMM_HI_W-1:0] hi,
                                                    input logic [REG_W-1:0]    rd);
        return {hi, rd, OP_LUI};
    endfunction

    // ADDI rd, rs1, lo
    function automatic logic [WORD_LEN-1:0] enc_addi(input logic [IMM_LO_W-1:0] lo,
                                                     input logic [REG_W-1:0]    rs1,
                                                     input logic [REG_W-1:0]    rd);
        return {lo, rs1, F3_ADDI, rd, OP_IMM};
    endfunction

endpackage

// File: rtl/li_split.sv
// Splits a 32-bit constant into LUI/ADDI immediates and flags which are needed.
//   in_imm    : constant to materialise
//   hi        : upper 20 bits, pre-compensated for ADDI sign extension of lo
//   lo        : low 12 bits
//   need_lui  : hi is non-zero
//   need_addi : lo is non-zero, or hi is zero (ADDI alone must carry the value)
module li_split
    import li_expander_pkg::*;
(
    input  logic [WORD_LEN-1:0] in_imm,
    output logic [IMM_HI_W-1:0] hi,
    output logic [IMM_LO_W-1:0] lo,
    output logic                need_lui,
    output logic                need_addi
);

    // (imm + 0x800) >> 12 == imm[31:12] + imm[11], wrapping at 20 bits
    always_comb begin
        lo        = in_imm[IMM_LO_W-1:0];
        hi        = in_imm[WORD_LEN-1:IMM_LO_W] + IMM_HI_W'(in_imm[IMM_LO_W-1]);
        need_lui  = (hi != '0);
        need_addi = (lo != '0) || (hi == '0);
    end

endmodule

// File: rtl/li_expander.sv
// Load-immediate pseudo-instruction expander: turns {imm, rd} into the minimal
// RV32I sequence (ADDI, LUI, or LUI+ADDI) over valid/ready handshakes.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid/in_ready    : request handshake (ready only while idle)
//   in_imm, in_rd        : constant and destination register
//   out_valid/out_ready  : instruction handshake
//   out_instr, out_last  : encoded instruction, final-of-sequence flag
module li_expander
    import li_expander_pkg::*;
#(
    parameter int unsigned W = WORD_LEN
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_imm,
    input  logic [REG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_instr,
    output logic             out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        LAST  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        out_instr_d;
    logic [W-1:0]        pend_q, pend_d;
    logic [IMM_HI_W-1:0] hi;
    logic [IMM_LO_W-1:0] lo;
    logic                need_lui, need_addi;

    li_split u_split (
        .in_imm    (in_imm),
        .hi        (hi),
        .lo        (lo),
        .need_lui  (need_lui),
        .need_addi (need_addi)
    );

    // Next state, next instruction, and the ADDI parked while LUI is presented
    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr;
        pend_d      = pend_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_rd == '0) begin
                        out_instr_d = NOP_INSTR;
                        state_d     = LAST;
                    end else if (need_lui && need_addi) begin
                        out_instr_d = enc_lui(hi, in_rd);
                        pend_d      = enc_addi(lo, in_rd, in_rd);
                        state_d     = FIRST;
                    end else if (need_lui) begin
                        out_instr_d = enc_lui(hi, in_rd);
                        state_d     = LAST;
                    end else begin
                        out_instr_d = enc_addi(lo, REG_W'(0), in_rd);
                        state_d     = LAST;
                    end
                end
            end
            FIRST: begin
                if (out_ready) begin
                    out_instr_d = pend_q;
                    state_d     = LAST;
                end
            end
            LAST: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            out_instr <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            out_instr <= out_instr_d;
            out_valid <= (state_d != IDLE);
            out_last  <= (state_d == LAST);
            in_ready  <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: directed vector table, backpressure and
// mid-sequence reset sequences, then random requests against a reference model.
module tb_li_expander;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    li_expander dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  rd;
        int          n;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value-level rules, hi from a plain wrapping add and shift
    function automatic int model(input logic [31:0] imm, input logic [4:0] rd,
                                 output logic [31:0] i0, output logic [31:0] i1);
        logic [19:0] hi;
        logic [11:0] lo;
        hi = 20'((imm + 32'h800) >> 12);
        lo = imm[11:0];
        i0 = 32'h0;
        i1 = 32'h0;
        if (rd == 5'd0) begin
            i0 = 32'h0000_0013;
            return 1;
        end
        if (hi == 20'd0) begin
            i0 = {lo, 5'd0, 3'b000, rd, 7'b0010011};
            return 1;
        end
        if (lo == 12'd0) begin
            i0 = {hi, rd, 7'b0110111};
            return 1;
        end
        i0 = {hi, rd, 7'b0110111};
        i1 = {lo, rd, 3'b000, rd, 7'b0010011};
        return 2;
    endfunction

    // Present a request until accepted; scramble inputs afterwards
    task automatic issue(input logic [31:0] imm, input logic [4:0] rd, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_rd    = rd;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_imm   = $urandom;
        in_rd    = 5'($urandom);
    endtask

    // Wait for one output handshake, optionally stalling at random
    task automatic take(input bit stall, output logic [31:0] ins, output logic l, output bit ok);
        ok  = 1'b0;
        ins = 32'h0;
        l   = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                ins = out_instr;
                l   = out_last;
                ok  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [31:0] imm, input logic [4:0] rd,
                           input bit stall);
        logic [31:0] e0, e1, ins;
        logic        l;
        bit          ok;
        int          n;
        n = model(imm, rd, e0, e1);
        issue(imm, rd, ok);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        chk({tag, "_valid_next"}, 32'(out_valid), 32'd1);
        for (int k = 0; k < n; k++) begin
            take(stall, ins, l, ok);
            chk({tag, "_handshake"}, 32'(ok), 32'd1);
            chk({tag, "_instr"}, ins, (k == 0) ? e0 : e1);
            chk({tag, "_last"}, 32'(l), 32'(k == n - 1));
        end
        chk({tag, "_idle_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ins, imm;
        logic [4:0]  rd;
        logic        l;
        bit          ok;

        vecs[0] = '{32'h12345678, 5'd5, 2, 32'h123452B7, 32'h67828293};
        vecs[1] = '{32'h12345800, 5'd6, 2, 32'h12346337, 32'h80030313};
        vecs[2] = '{32'hFFFFF800, 5'd5, 1, 32'h80000293, 32'h0};
        vecs[3] = '{32'h00001000, 5'd5, 1, 32'h000012B7, 32'h0};
        vecs[4] = '{32'h00000000, 5'd5, 1, 32'h00000293, 32'h0};
        vecs[5] = '{32'hDEADBEEF, 5'd0, 1, 32'h00000013, 32'h0};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_imm    = 32'h0;
        in_rd     = 5'd0;
        out_ready = 1'b0;
        #23;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // out_ready while idle must not start anything
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready_ignored", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Directed table: model-independent constants
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].imm, vecs[v].rd, ok);
            chk($sformatf("vec%0d_accept", v), 32'(ok), 32'd1);
            for (int k = 0; k < vecs[v].n; k++) begin
                take(1'b0, ins, l, ok);
                chk($sformatf("vec%0d_hs%0d", v, k), 32'(ok), 32'd1);
                chk($sformatf("vec%0d_instr%0d", v, k), ins, (k == 0) ? vecs[v].i0 : vecs[v].i1);
                chk($sformatf("vec%0d_last%0d", v, k), 32'(l), 32'(k == vecs[v].n - 1));
            end
            chk($sformatf("vec%0d_done", v), 32'(out_valid), 32'd0);
        end

        // Backpressure in FIRST with a second request waiting
        issue(32'h12345678, 5'd5, ok);
        chk("bp_accept", 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_imm   = 32'h00001000;
        in_rd    = 5'd7;
        for (int c = 0; c < 5; c++) begin
            chk("bp_instr_stable", out_instr, 32'h123452B7);
            chk("bp_last_low", 32'(out_last), 32'd0);
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        take(1'b0, ins, l, ok);
        chk("bp_lui", ins, 32'h123452B7);
        chk("bp_in_ready_low2", 32'(in_ready), 32'd0);
        take(1'b0, ins, l, ok);
        chk("bp_addi", ins, 32'h67828293);
        chk("bp_addi_last", 32'(l), 32'd1);
        issue(32'h00001000, 5'd7, ok);
        chk("bp_second_accept", 32'(ok), 32'd1);
        take(1'b0, ins, l, ok);
        chk("bp_second_instr", ins, 32'h000013B7);
        chk("bp_second_last", 32'(l), 32'd1);

        // Reset while in FIRST
        issue(32'h12345678, 5'd5, ok);
        chk("rm_accept", 32'(ok), 32'd1);
        chk("rm_in_first", 32'(out_last), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rm_valid_drop", 32'(out_valid), 32'd0);
        chk("rm_instr_clear", out_instr, 32'h0);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rm_idle_ready", 32'(in_ready), 32'd1);
        chk("rm_idle_valid", 32'(out_valid), 32'd0);
        run_req("rm_next", 32'h12345800, 5'd6, 1'b0);

        // Random requests, some biased toward the single-instruction corners
        for (int t = 0; t < 150; t++) begin
            imm = $urandom;
            case ($urandom_range(0, 4))
                0: imm[11:0] = 12'h000;
                1: imm = 32'($signed(imm[11:0]));
                2: imm[11:0] = 12'h800;
                default: ;
            endcase
            rd = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            run_req("rnd", imm, rd, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
